// File: rtl/cla_wide_add_seq_pkg.sv
// Shared ALU package for the wide-add sequencer: sequencer state encoding
// and the width of the single adder slice that is reused every cycle.
package cla_wide_add_seq_pkg;

  localparam int SLICE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_wide_add_seq_cla64.sv
// 64-bit carry-look-ahead adder (CLA_64Bit_Adder role). Two lookahead levels:
// 4-bit groups and 16-bit super-groups. The super-group carries resolve first,
// then the group carries, then the bit carries.
module cla_wide_add_seq_cla64
  import cla_wide_add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [63:0] g_s;
  logic [63:0] p_s;
  logic [15:0] gg_s;
  logic [15:0] gp_s;
  logic [3:0]  sg_s;
  logic [3:0]  sp_s;
  logic [4:0]  sc_s;
  logic [15:0] gc_s;
  logic [63:0] c_s;

  // Generate/propagate tree and carry resolution for the whole 64-bit slice.
  always_comb begin
    g_s  = a & b;
    p_s  = a ^ b;
    gg_s = 16'd0;
    gp_s = 16'd0;
    sg_s = 4'd0;
    sp_s = 4'd0;
    sc_s = 5'd0;
    gc_s = 16'd0;
    c_s  = 64'd0;

    // Level 1: 4-bit group generate/propagate.
    for (int i = 0; i < 16; i++) begin
      gg_s[i] = g_s[4*i+3]
              | (p_s[4*i+3] & g_s[4*i+2])
              | (p_s[4*i+3] & p_s[4*i+2] & g_s[4*i+1])
              | (p_s[4*i+3] & p_s[4*i+2] & p_s[4*i+1] & g_s[4*i]);
      gp_s[i] = &p_s[4*i +: 4];
    end

    // Level 2: 16-bit super-group generate/propagate.
    for (int j = 0; j < 4; j++) begin
      sg_s[j] = gg_s[4*j+3]
              | (gp_s[4*j+3] & gg_s[4*j+2])
              | (gp_s[4*j+3] & gp_s[4*j+2] & gg_s[4*j+1])
              | (gp_s[4*j+3] & gp_s[4*j+2] & gp_s[4*j+1] & gg_s[4*j]);
      sp_s[j] = &gp_s[4*j +: 4];
    end

    // Super-group carries.
    sc_s[0] = cin;
    for (int j = 0; j < 4; j++) begin
      sc_s[j+1] = sg_s[j] | (sp_s[j] & sc_s[j]);
    end

    // Group carries inside each super-group.
    for (int j = 0; j < 4; j++) begin
      gc_s[4*j] = sc_s[j];
      for (int m = 0; m < 3; m++) begin
        gc_s[4*j+m+1] = gg_s[4*j+m] | (gp_s[4*j+m] & gc_s[4*j+m]);
      end
    end

    // Bit carries inside each 4-bit group.
    for (int i = 0; i < 16; i++) begin
      c_s[4*i] = gc_s[i];
      for (int m = 0; m < 3; m++) begin
        c_s[4*i+m+1] = g_s[4*i+m] | (p_s[4*i+m] & c_s[4*i+m]);
      end
    end
  end

  assign sum  = p_s ^ c_s;
  assign cout = sc_s[4];

endmodule

// File: rtl/cla_wide_add_seq.sv
// Wide adder sequencer: computes WIDTH-bit A+B (optionally A-B) by reusing one
// 64-bit CLA over WIDTH/64 slices, one slice per cycle, with the carry kept in
// a register between slices. Valid/ready handshake on input and output.
// Optional feature macro: WIDE_ADD_SUB_EN (adds the Sub port; subtract latches
// ~B and starts with carry 1). Without it, only addition is supported.
module cla_wide_add_seq
  import cla_wide_add_seq_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef WIDE_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e                    state_r;
  logic [N-1:0][SLICE_W-1:0] a_r;
  logic [N-1:0][SLICE_W-1:0] b_r;
  logic [N-1:0][SLICE_W-1:0] s_r;
  logic                      carry_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      co_r;
  logic                      out_valid_r;

  logic                      sub_s;
  logic [WIDTH-1:0]          b_latch_s;
  logic                      in_ready_s;
  logic                      accept_s;
  logic [SLICE_W-1:0]        a_slice_s;
  logic [SLICE_W-1:0]        b_slice_s;
  logic [SLICE_W-1:0]        sum_s;
  logic                      cout_s;

  // Operation select and the B value to capture at accept (inverted for subtract).
  always_comb begin
`ifdef WIDE_ADD_SUB_EN
    sub_s = Sub;
`else
    sub_s = 1'b0;
`endif
    if (sub_s) begin
      b_latch_s = ~B;
    end else begin
      b_latch_s = B;
    end
  end

  // Request acceptance: free when idle, or when the held result leaves this cycle.
  always_comb begin
    if (Rst) begin
      in_ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else if (state_r == DONE) begin
      in_ready_s = OutReady;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = InValid && in_ready_s;
  end

  // Route the current slice of the latched operands to the shared adder.
  always_comb begin
    a_slice_s = a_r[idx_r];
    b_slice_s = b_r[idx_r];
  end

  cla_wide_add_seq_cla64 u_cla64 (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Sequencer FSM: latch at accept, one slice per RUN cycle, hold in DONE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      s_r         <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      co_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= A;
            b_r     <= b_latch_s;
            carry_r <= sub_s;
            idx_r   <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          s_r[idx_r] <= sum_s;
          carry_r    <= cout_s;
          if (idx_r == LAST_IDX) begin
            co_r        <= cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (OutReady) begin
            out_valid_r <= 1'b0;
            if (accept_s) begin
              a_r     <= A;
              b_r     <= b_latch_s;
              carry_r <= sub_s;
              idx_r   <= '0;
              state_r <= RUN;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = in_ready_s;
  assign OutValid = out_valid_r;
  assign S        = s_r;
  assign CO       = co_r;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Self-checking bench for cla_wide_add_seq (WIDTH = 256). Results are
// compared against plain wide arithmetic; subtract tests are built only
// when WIDE_ADD_SUB_EN is defined.
module tb_cla_wide_add_seq;

  localparam int WIDTH = 256;
  localparam int N     = WIDTH / 64;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef WIDE_ADD_SUB_EN
  logic             Sub;
`endif
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] S;
  logic             CO;

  int checks = 0;
  int errors = 0;

  cla_wide_add_seq #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
`ifdef WIDE_ADD_SUB_EN
    .Sub      (Sub),
`endif
    .OutValid (OutValid),
    .OutReady (OutReady),
    .S        (S),
    .CO       (CO)
  );

  always #5 Clk = ~Clk;

  // Reference: {CO, S} straight from wide arithmetic.
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sub);
    logic [WIDTH:0] r;
    if (sub) begin
      r[WIDTH-1:0] = a - b;
      r[WIDTH]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_sub(input logic sub);
`ifdef WIDE_ADD_SUB_EN
    Sub = sub;
`endif
  endtask

  // Waits for OutValid, returning the number of edges waited (bounded).
  task automatic wait_valid(output int cyc, input bit scramble);
    cyc = 0;
    while (OutValid !== 1'b1 && cyc < 20) begin
      if (scramble) begin
        A = rand_wide();
        B = rand_wide();
        set_sub(1'($urandom_range(0, 1)));
      end
      step();
      cyc++;
    end
  endtask

  // One full transaction: accept, latency check, result check, consume.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input bit scramble, input string tag);
    logic [WIDTH:0] exp;
    int cyc;
    exp = ref_result(a, b, sub);
    A = a;
    B = b;
    set_sub(sub);
    InValid = 1'b1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b want 1", tag, InReady);
    end
    step();
    InValid = 1'b0;
    wait_valid(cyc, scramble);
    checks++;
    if (cyc !== N) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, cyc, N);
    end
    checks++;
    if ({CO, S} !== exp) begin
      errors++;
      $display("FAIL %s result: got CO=%b S=%h want CO=%b S=%h",
               tag, CO, S, exp[WIDTH], exp[WIDTH-1:0]);
    end
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL %s consume: got OutValid=%b want 0", tag, OutValid);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step();
    step();
    checks++;
    if (OutValid !== 1'b0 || S !== '0 || CO !== 1'b0 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got OutValid=%b CO=%b InReady=%b S=%h want 0 0 0 0",
               OutValid, CO, InReady, S);
    end
    Rst = 1'b0;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready: got %b want 1", InReady);
    end
  endtask

  task automatic test_carry_chain();
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] low64;
    ones  = '1;
    low64 = '0;
    low64[63:0] = '1;
    run_op(ones, WIDTH'(1), 1'b0, 1'b0, "all_ones_plus_1");
    run_op(low64, WIDTH'(1), 1'b0, 1'b0, "slice_carry");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(rand_wide(), rand_wide(), 1'b0, 1'b0, "random_add");
    end
  endtask

  task automatic test_operand_change();
    for (int i = 0; i < 3; i++) begin
      run_op(rand_wide(), rand_wide(), 1'b0, 1'b1, "operand_change");
    end
  endtask

`ifdef WIDE_ADD_SUB_EN
  task automatic test_subtract();
    run_op(WIDTH'(0), WIDTH'(1), 1'b1, 1'b0, "sub_0_minus_1");
    run_op(WIDTH'(5), WIDTH'(3), 1'b1, 1'b0, "sub_5_minus_3");
    for (int i = 0; i < 4; i++) begin
      run_op(rand_wide(), rand_wide(), 1'b1, 1'b0, "random_sub");
    end
  endtask
`endif

  task automatic test_backpressure();
    logic [WIDTH-1:0] a1, b1, a2, b2;
    logic [WIDTH:0]   exp1, exp2;
    int cyc;
    a1 = rand_wide(); b1 = rand_wide();
    a2 = rand_wide(); b2 = rand_wide();
    exp1 = ref_result(a1, b1, 1'b0);
    exp2 = ref_result(a2, b2, 1'b0);
    A = a1; B = b1; set_sub(1'b0);
    InValid = 1'b1;
    step();
    InValid = 1'b0;
    wait_valid(cyc, 1'b0);
    checks++;
    if (cyc !== N) begin
      errors++;
      $display("FAIL bp_first_latency: got %0d want %0d", cyc, N);
    end
    // Stall: requests offered but must be refused, result must stay put.
    A = a2; B = b2; InValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || {CO, S} !== exp1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got OutValid=%b InReady=%b CO=%b S=%h want 1 0 %b %h",
                 i, OutValid, InReady, CO, S, exp1[WIDTH], exp1[WIDTH-1:0]);
      end
    end
    OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL bp_release in_ready: got %b want 1", InReady);
    end
    step();
    OutReady = 1'b0;
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_consume: got OutValid=%b want 0", OutValid);
    end
    wait_valid(cyc, 1'b0);
    checks++;
    if (cyc !== N) begin
      errors++;
      $display("FAIL bp_second_latency: got %0d want %0d", cyc, N);
    end
    checks++;
    if ({CO, S} !== exp2) begin
      errors++;
      $display("FAIL bp_second_result: got CO=%b S=%h want CO=%b S=%h",
               CO, S, exp2[WIDTH], exp2[WIDTH-1:0]);
    end
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    A = '1; B = '1; set_sub(1'b0);
    InValid = 1'b1;
    step();
    InValid = 1'b0;
    step();
    step();
    Rst = 1'b1;
    step();
    checks++;
    if (OutValid !== 1'b0 || S !== '0 || CO !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got OutValid=%b CO=%b S=%h want 0 0 0", OutValid, CO, S);
    end
    Rst = 1'b0;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL midrun_in_ready: got %b want 1", InReady);
    end
    seen = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (OutValid === 1'b1) seen = 1'b1;
    end
    OutReady = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_emit: got OutValid seen=%b want 0", seen);
    end
    run_op(rand_wide(), rand_wide(), 1'b0, 1'b0, "after_midrun_reset");
  endtask

  initial begin
    Rst = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b0;
    A = '0;
    B = '0;
    set_sub(1'b0);
    test_reset();
    test_carry_chain();
    test_random();
`ifdef WIDE_ADD_SUB_EN
    test_subtract();
`endif
    test_backpressure();
    test_reset_mid_run();
    test_operand_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
